// File: rtl/bicubic_write_bmp.sv
// Turns a raster-order 24-bit RGB pixel stream into a byte-addressed 24-bit BMP file image.
// Emits the 54-byte header, then rows bottom-up in B,G,R order with each row padded to 4 bytes.
module bicubic_write_bmp #(
    parameter int WIDTH  = 3840,
    parameter int HEIGHT = 2160,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [23:0]       s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [7:0]        m_data,
    output logic              busy,
    output logic              done
);
    localparam int STRIDE     = ((WIDTH * 3 + 3) / 4) * 4;
    localparam int PAD        = STRIDE - WIDTH * 3;
    localparam int IMG_BYTES  = STRIDE * HEIGHT;
    localparam int FILE_BYTES = 54 + IMG_BYTES;
    localparam int ROW0_BASE  = 54 + (HEIGHT - 1) * STRIDE;
    localparam int COL_W      = $clog2(WIDTH + 1);
    localparam int ROW_W      = $clog2(HEIGHT + 1);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] ROW0_A   = ADDR_W'(ROW0_BASE);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_PIX  = 3'd2;
    localparam logic [2:0] S_BYTE = 3'd3;
    localparam logic [2:0] S_PAD  = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    // Past the 'BM' signature every header field falls on a 4-byte boundary relative to byte 2.
    function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
        logic [5:0]  rel;
        logic [31:0] f;
        rel = idx - 6'd2;
        case (rel[5:2])
            4'd0:    f = 32'(FILE_BYTES);
            4'd2:    f = 32'd54;
            4'd3:    f = 32'd40;
            4'd4:    f = 32'(WIDTH);
            4'd5:    f = 32'(HEIGHT);
            4'd6:    f = 32'h0018_0001;
            4'd8:    f = 32'(IMG_BYTES);
            4'd9:    f = 32'd2835;
            4'd10:   f = 32'd2835;
            default: f = 32'd0;
        endcase
        if (idx < 6'd2) return idx[0] ? 8'h4D : 8'h42;
        return 8'(f >> {rel[1:0], 3'b000});
    endfunction

    logic [2:0]        state_q, state_d;
    logic [5:0]        hdr_idx_q, hdr_idx_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [1:0]        k_q, k_d;
    logic [1:0]        pad_cnt_q, pad_cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rowbase_q, rowbase_d;
    logic [23:0]       pix_q, pix_d;
    logic              m_valid_q, m_valid_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [7:0]        m_data_q, m_data_d;
    logic              m_hs, last_col, row_end;
    logic [5:0]        hdr_next;

    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        col_d     = col_q;
        row_d     = row_q;
        k_d       = k_q;
        pad_cnt_d = pad_cnt_q;
        ptr_d     = ptr_q;
        rowbase_d = rowbase_q;
        pix_d     = pix_q;
        m_valid_d = m_valid_q;
        m_addr_d  = m_addr_q;
        m_data_d  = m_data_q;
        s_ready   = 1'b0;
        row_end   = 1'b0;
        m_hs      = m_valid_q && m_ready;
        last_col  = (col_q == COL_W'(WIDTH - 1));
        hdr_next  = hdr_idx_q + 6'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_HDR;
                    hdr_idx_d = 6'd0;
                    m_valid_d = 1'b1;
                    m_addr_d  = '0;
                    m_data_d  = hdr_byte(6'd0);
                end
            end
            S_HDR: begin
                if (m_hs) begin
                    if (hdr_idx_q == 6'd53) begin
                        m_valid_d = 1'b0;
                        row_d     = '0;
                        col_d     = '0;
                        rowbase_d = ROW0_A;
                        ptr_d     = ROW0_A;
                        state_d   = S_PIX;
                    end else begin
                        hdr_idx_d = hdr_next;
                        m_addr_d  = {{(ADDR_W - 6){1'b0}}, hdr_next};
                        m_data_d  = hdr_byte(hdr_next);
                    end
                end
            end
            S_PIX: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    pix_d     = s_data;
                    k_d       = 2'd0;
                    m_valid_d = 1'b1;
                    m_addr_d  = ptr_q;
                    m_data_d  = s_data[7:0];
                    state_d   = S_BYTE;
                end
            end
            S_BYTE: begin
                // Accepting the next pixel alongside the R byte keeps a row at 3 cycles per pixel.
                s_ready = (k_q == 2'd2) && m_hs && !last_col;
                if (m_hs) begin
                    ptr_d    = ptr_q + 1'b1;
                    m_addr_d = ptr_q + 1'b1;
                    if (k_q != 2'd2) begin
                        k_d      = k_q + 2'd1;
                        m_data_d = (k_q == 2'd0) ? pix_q[15:8] : pix_q[23:16];
                    end else if (!last_col) begin
                        col_d = col_q + 1'b1;
                        if (s_valid) begin
                            pix_d    = s_data;
                            k_d      = 2'd0;
                            m_data_d = s_data[7:0];
                        end else begin
                            m_valid_d = 1'b0;
                            state_d   = S_PIX;
                        end
                    end else if (PAD > 0) begin
                        pad_cnt_d = 2'd0;
                        m_data_d  = 8'h00;
                        state_d   = S_PAD;
                    end else begin
                        row_end = 1'b1;
                    end
                end
            end
            S_PAD: begin
                if (m_hs) begin
                    if (pad_cnt_q == 2'(PAD - 1)) begin
                        row_end = 1'b1;
                    end else begin
                        pad_cnt_d = pad_cnt_q + 2'd1;
                        ptr_d     = ptr_q + 1'b1;
                        m_addr_d  = ptr_q + 1'b1;
                        m_data_d  = 8'h00;
                    end
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Rows are written bottom-up, so each new row starts one stride below the previous one.
        if (row_end) begin
            m_valid_d = 1'b0;
            if (row_q == ROW_W'(HEIGHT - 1)) begin
                state_d = S_FIN;
            end else begin
                row_d     = row_q + 1'b1;
                col_d     = '0;
                rowbase_d = rowbase_q - STRIDE_A;
                ptr_d     = rowbase_q - STRIDE_A;
                state_d   = S_PIX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hdr_idx_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            k_q       <= '0;
            pad_cnt_q <= '0;
            ptr_q     <= '0;
            rowbase_q <= '0;
            pix_q     <= '0;
            m_valid_q <= 1'b0;
            m_addr_q  <= '0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            col_q     <= col_d;
            row_q     <= row_d;
            k_q       <= k_d;
            pad_cnt_q <= pad_cnt_d;
            ptr_q     <= ptr_d;
            rowbase_q <= rowbase_d;
            pix_q     <= pix_d;
            m_valid_q <= m_valid_d;
            m_addr_q  <= m_addr_d;
            m_data_q  <= m_data_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_addr  = m_addr_q;
    assign m_data  = m_data_q;
    assign busy    = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done    = (state_q == S_FIN);
endmodule

// File: tb/tb_bicubic_write_bmp.sv
// Bench for bicubic_write_bmp: a 3x2 frame (padded rows) and a 4x2 frame (no padding) run side by side.
module tb_bicubic_write_bmp;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        s_valid [2];
    logic        s_ready [2];
    logic [23:0] s_data  [2];
    logic        m_valid [2];
    logic        m_ready [2];
    logic [31:0] m_addr  [2];
    logic [7:0]  m_data  [2];
    logic        busy    [2];
    logic        done    [2];

    always #5 clk = ~clk;

    bicubic_write_bmp #(.WIDTH(3), .HEIGHT(2), .ADDR_W(32)) dut0 (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_addr(m_addr[0]), .m_data(m_data[0]),
        .busy(busy[0]), .done(done[0]));

    bicubic_write_bmp #(.WIDTH(4), .HEIGHT(2), .ADDR_W(32)) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_addr(m_addr[1]), .m_data(m_data[1]),
        .busy(busy[1]), .done(done[1]));

    typedef struct {
        string      name;
        int         dut;
        int         addr;
        logic [7:0] exp;
    } spot_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit rand_mode = 0;
    int wdt [2] = '{3, 4};
    int npix [2] = '{6, 8};
    logic [23:0] pixtab [2][8];
    int pix_idx [2];
    logic [39:0] cap0[$], cap1[$], ref0[$], ref1[$];
    int st0[$], st1[$];
    int done_cnt [2], done_cyc [2], last_hs [2];
    bit hold_v [2];
    logic [31:0] hold_a [2];
    logic [7:0]  hold_d [2];
    logic [7:0]  img [2][128];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sample at the falling edge, advance the pixel source after the rising edge.
    task automatic step();
        bit hs_s [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            hs_s[d] = s_valid[d] && s_ready[d];
            if (hold_v[d]) begin
                chk($sformatf("d%0d_hold_valid", d), m_valid[d], 1'b1);
                chk($sformatf("d%0d_hold_addr", d), m_addr[d], hold_a[d]);
                chk($sformatf("d%0d_hold_data", d), m_data[d], hold_d[d]);
            end
            hold_v[d] = m_valid[d] && !m_ready[d];
            hold_a[d] = m_addr[d];
            hold_d[d] = m_data[d];
            if (m_valid[d] && m_ready[d]) begin
                last_hs[d] = cyc;
                if (d == 0) cap0.push_back({m_addr[d], m_data[d]});
                else        cap1.push_back({m_addr[d], m_data[d]});
            end
            if (done[d]) begin
                done_cnt[d]++;
                done_cyc[d] = cyc;
            end
            if (hs_s[d]) begin
                if (d == 0) st0.push_back(cyc);
                else        st1.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (hs_s[d]) pix_idx[d]++;
            s_valid[d] = (pix_idx[d] < npix[d]);
            s_data[d]  = (pix_idx[d] < 8) ? pixtab[d][pix_idx[d]] : 24'h0;
            m_ready[d] = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic begin_frame(input bit rnd);
        rand_mode = rnd;
        cap0.delete(); cap1.delete(); st0.delete(); st1.delete();
        for (int d = 0; d < 2; d++) begin
            pix_idx[d] = 0; done_cnt[d] = 0; done_cyc[d] = -1; last_hs[d] = -1;
            s_valid[d] = 1'b1; s_data[d] = pixtab[d][0];
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_first_valid", d), m_valid[d], 1'b1);
            chk($sformatf("d%0d_first_addr", d), m_addr[d], 32'd0);
            chk($sformatf("d%0d_first_data", d), m_data[d], 8'h42);
            chk($sformatf("d%0d_busy_start", d), busy[d], 1'b1);
        end
    endtask

    task automatic run_frame(input bit rnd);
        int i;
        begin_frame(rnd);
        for (i = 0; i < 3000 && !(done_cnt[0] > 0 && done_cnt[1] > 0); i++) step();
        chk("frame_timeout", (done_cnt[0] > 0 && done_cnt[1] > 0), 1'b1);
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_done_pulses", d), done_cnt[d], 1);
            chk($sformatf("d%0d_done_timing", d), done_cyc[d], last_hs[d] + 1);
            chk($sformatf("d%0d_busy_end", d), busy[d], 1'b0);
        end
    endtask

    // Reference image in handshake order, placing bytes by the closed-form address.
    task automatic build_ref(input int d);
        logic [39:0] q[$];
        logic [7:0]  h [54];
        logic [31:0] f [13];
        int w, stride, pad;
        w = wdt[d];
        stride = ((w * 3 + 3) / 4) * 4;
        pad = stride - w * 3;
        f = '{32'(54 + stride * 2), 0, 54, 40, 32'(w), 2, 32'h0018_0001, 0,
              32'(stride * 2), 2835, 2835, 0, 0};
        h[0] = 8'h42;
        h[1] = 8'h4D;
        for (int n = 0; n < 13; n++)
            for (int b = 0; b < 4; b++) h[2 + 4 * n + b] = 8'(f[n] >> (8 * b));
        for (int a = 0; a < 54; a++) q.push_back({32'(a), h[a]});
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < w; c++)
                for (int k = 0; k < 3; k++)
                    q.push_back({32'(54 + (1 - r) * stride + 3 * c + k),
                                 8'(pixtab[d][r * w + c] >> (8 * k))});
            for (int p = 0; p < pad; p++) q.push_back({32'(54 + (1 - r) * stride + 3 * w + p), 8'h00});
        end
        if (d == 0) ref0 = q; else ref1 = q;
    endtask

    task automatic cmp_ref(input int d, input string tag);
        logic [39:0] c[$], r[$];
        if (d == 0) begin c = cap0; r = ref0; end
        else        begin c = cap1; r = ref1; end
        chk($sformatf("%s_d%0d_count", tag, d), c.size(), r.size());
        for (int i = 0; i < c.size() && i < r.size(); i++)
            chk($sformatf("%s_d%0d_byte%0d", tag, d, i), c[i], r[i]);
    endtask

    spot_t spots [21];
    int gap0 [5] = '{3, 3, 7, 3, 3};
    int gap1 [7] = '{3, 3, 3, 4, 3, 3, 3};

    initial begin
        pixtab[0] = '{24'hAABBCC, 24'h112233, 24'h445566, 24'h778899, 24'hDDEEFF, 24'h102030, 0, 0};
        pixtab[1] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C,
                      24'h0D0E0F, 24'h101112, 24'h131415, 24'h161718};
        spots = '{
            '{"sig_b", 0, 0, 8'h42},   '{"sig_m", 0, 1, 8'h4D},   '{"file_size", 0, 2, 8'h4E},
            '{"data_off", 0, 10, 8'h36}, '{"width", 0, 18, 8'h03}, '{"height", 0, 22, 8'h02},
            '{"bpp", 0, 28, 8'h18},    '{"img_size", 0, 34, 8'h18}, '{"p00_b", 0, 66, 8'hCC},
            '{"p00_g", 0, 67, 8'hBB},  '{"p00_r", 0, 68, 8'hAA},  '{"pad0", 0, 75, 8'h00},
            '{"pad1", 0, 76, 8'h00},   '{"pad2", 0, 77, 8'h00},   '{"p10_b", 0, 54, 8'h99},
            '{"p10_g", 0, 55, 8'h88},  '{"p10_r", 0, 56, 8'h77},  '{"w4_file_size", 1, 2, 8'h4E},
            '{"w4_width", 1, 18, 8'h04}, '{"w4_p03_r", 1, 77, 8'h0A}, '{"w4_p10_b", 1, 54, 8'h0F}};
        build_ref(0);
        build_ref(1);

        rst = 1'b1;
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = 1'b0; s_data[d] = '0; m_ready[d] = 1'b1; hold_v[d] = 0;
        end
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_m_valid", d), m_valid[d], 1'b0);
            chk($sformatf("d%0d_rst_s_ready", d), s_ready[d], 1'b0);
            chk($sformatf("d%0d_rst_busy", d), busy[d], 1'b0);
            chk($sformatf("d%0d_rst_done", d), done[d], 1'b0);
        end
        rst = 1'b0;
        step();

        // Frame with m_ready held high: full image, spot values, pixel acceptance rhythm.
        run_frame(1'b0);
        cmp_ref(0, "ready1");
        cmp_ref(1, "ready1");
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 128; a++) img[d][a] = 8'hXX;
        foreach (cap0[i]) if (cap0[i][39:8] < 128) img[0][cap0[i][39:8]] = cap0[i][7:0];
        foreach (cap1[i]) if (cap1[i][39:8] < 128) img[1][cap1[i][39:8]] = cap1[i][7:0];
        for (int i = 0; i < 21; i++)
            chk(spots[i].name, img[spots[i].dut][spots[i].addr], spots[i].exp);
        chk("w4_row0_end_addr", (cap1.size() > 66) ? cap1[65][39:8] : 32'hFFFF_FFFF, 32'd77);
        chk("w4_row1_start_addr", (cap1.size() > 66) ? cap1[66][39:8] : 32'hFFFF_FFFF, 32'd54);
        chk("d0_pixels_taken", st0.size(), 6);
        chk("d1_pixels_taken", st1.size(), 8);
        for (int i = 0; i < 5 && i + 1 < st0.size(); i++)
            chk($sformatf("d0_s_gap%0d", i), st0[i + 1] - st0[i], gap0[i]);
        for (int i = 0; i < 7 && i + 1 < st1.size(); i++)
            chk($sformatf("d1_s_gap%0d", i), st1[i + 1] - st1[i], gap1[i]);

        // Randomly stalled downstream: same byte sequence, outputs held while stalled.
        run_frame(1'b1);
        cmp_ref(0, "stall");
        cmp_ref(1, "stall");

        // Reset in the middle of the first pixel row, then a clean frame.
        begin_frame(1'b0);
        for (int i = 0; i < 200 && cap0.size() < 60; i++) step();
        chk("midrow_reached", cap0.size() >= 60, 1'b1);
        rst = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_midrst_m_valid", d), m_valid[d], 1'b0);
            chk($sformatf("d%0d_midrst_busy", d), busy[d], 1'b0);
            hold_v[d] = 0;
        end
        rst = 1'b0;
        step();
        chk("d0_idle_after_rst", m_valid[0], 1'b0);
        run_frame(1'b0);
        cmp_ref(0, "after_rst");
        cmp_ref(1, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
